// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: register-bank FSM states and architectural
// register indices used by the register bank and its clear sequencer.
package legv8_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int XZR = 31;
  localparam int SP  = 28;
  localparam int FP  = 29;
  localparam int LR  = 30;

  localparam int SP_INIT_DEFAULT = 65400;

endpackage

// File: rtl/legv8_regbank_param_if.sv
// Register-bank access bundle: decode read addresses, writeback port,
// debug display port and the clear-busy flag.
interface legv8_regbank_param_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] iReadRegister;
  logic [NUM_RD*DATA_W-1:0] oReadData;
  logic [ADDR_W-1:0]        iWriteRegister;
  logic [DATA_W-1:0]        iWriteData;
  logic                     iRegWrite;
  logic                     iWrite32;
  logic [ADDR_W-1:0]        iRegDispSelect;
  logic [DATA_W-1:0]        oRegDisp;
  logic                     oBusy;

  modport master (
    output iReadRegister, iWriteRegister, iWriteData, iRegWrite, iWrite32,
    output iRegDispSelect,
    input  oReadData, oRegDisp, oBusy
  );

  modport slave (
    input  iReadRegister, iWriteRegister, iWriteData, iRegWrite, iWrite32,
    input  iRegDispSelect,
    output oReadData, oRegDisp, oBusy
  );
endinterface

// File: rtl/legv8_regbank_clear_seq.sv
// Clear sequencer: walks every register index once after reset, zeroing
// each one except SP, which receives its initial stack value.
module legv8_regbank_clear_seq
  import legv8_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int NREGS   = 32,
  parameter int CNT_W   = 5,
  parameter int SP_REG  = SP,
  parameter int SP_INIT = SP_INIT_DEFAULT
) (
  input  logic              iCLK,
  input  logic              iCLR,
  output logic              clr_we,
  output logic [CNT_W-1:0]  clr_addr,
  output logic [DATA_W-1:0] clr_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NREGS - 1);
  localparam logic [CNT_W-1:0] SP_A = CNT_W'(SP_REG);

  state_e           state, state_n;
  logic [CNT_W-1:0] clr_cnt, clr_cnt_n;

  // State/counter register; reset (even mid-sequence) restarts from index 0.
  always_ff @(posedge iCLK) begin
    if (iCLR) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
    end
  end

  // Next-state: one register per cycle, return to IDLE after the last index.
  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = !iCLR;
        if (clr_cnt == LAST) begin
          state_n   = IDLE;
          clr_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign clr_addr = clr_cnt;
  assign clr_data = (clr_cnt == SP_A) ? DATA_W'(SP_INIT) : '0;
  assign busy     = (state == CLEAR);

endmodule

// File: rtl/legv8_regbank_param.sv
// Parametrised LEGv8 register bank: NUM_RD combinational read ports with
// optional write-to-read bypass, hardwired XZR, W-register writes and a
// sequenced post-reset clear.
module legv8_regbank_param
  import legv8_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = XZR,
  parameter int SP_REG   = SP,
  parameter int SP_INIT  = SP_INIT_DEFAULT,
  parameter int BYPASS   = 1
) (
  input  logic iCLK,
  input  logic iCLR,
  legv8_regbank_param_if.slave bus
);

  localparam int CNT_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [ADDR_W-1:0] XZR_A   = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W:0]   NREGS_A = (ADDR_W + 1)'(NREGS);

  logic [DATA_W-1:0] regs [NREGS];

  logic              clr_we;
  logic [CNT_W-1:0]  clr_addr;
  logic [DATA_W-1:0] clr_data;
  logic              busy;
  logic              wb_we;
  logic [DATA_W-1:0] wb_data;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] disp_data;

  // W-register writes keep only the low 32 bits, zero-extended.
  function automatic logic [DATA_W-1:0] wb_value(input logic [DATA_W-1:0] d,
                                                 input logic w32);
    logic [DATA_W-1:0] v;
    v = d;
    if (w32) v = DATA_W'(d[31:0]);
    return v;
  endfunction

  // Backed by storage: not XZR and inside the implemented register range.
  function automatic logic is_real(input logic [ADDR_W-1:0] a);
    return (a != XZR_A) && ({1'b0, a} < NREGS_A);
  endfunction

  legv8_regbank_clear_seq #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .CNT_W  (CNT_W),
    .SP_REG (SP_REG),
    .SP_INIT(SP_INIT)
  ) u_clear_seq (
    .iCLK    (iCLK),
    .iCLR    (iCLR),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .clr_data(clr_data),
    .busy    (busy)
  );

  // Reset takes priority over writeback; nothing lands while clearing.
  assign wb_we   = !busy && !iCLR && bus.iRegWrite && is_real(bus.iWriteRegister);
  assign wb_data = wb_value(bus.iWriteData, bus.iWrite32);

  // Storage write mux: clear sequencer or writeback port.
  always_ff @(posedge iCLK) begin
    if (clr_we) begin
      regs[clr_addr] <= clr_data;
    end else if (wb_we) begin
      regs[bus.iWriteRegister] <= wb_data;
    end
  end

  // Independent read ports, optionally forwarding this cycle's write value.
  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = bus.iReadRegister[k*ADDR_W +: ADDR_W];
      if (!busy && is_real(a)) begin
        if (BYPASS != 0 && wb_we && a == bus.iWriteRegister) begin
          rd_data[k*DATA_W +: DATA_W] = wb_data;
        end else begin
          rd_data[k*DATA_W +: DATA_W] = regs[a];
        end
      end
    end
  end

  // Debug display shows stored contents only, never the bypassed value.
  always_comb begin
    disp_data = '0;
    if (!busy && is_real(bus.iRegDispSelect)) begin
      disp_data = regs[bus.iRegDispSelect];
    end
  end

  assign bus.oReadData = rd_data;
  assign bus.oRegDisp  = disp_data;
  assign bus.oBusy     = busy;

endmodule

// File: tb/tb_legv8_regbank_param.sv
// Bench for legv8_regbank_param: one bypassing and one non-bypassing bank
// driven with identical stimulus and compared against a register-file model.
module tb_legv8_regbank_param;

  logic        iCLK = 1'b0;
  logic        clr;
  logic        we;
  logic        w32;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic [4:0]  ra0, ra1, disp;

  always #5 iCLK = ~iCLK;

  legv8_regbank_param_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) bus_b ();
  legv8_regbank_param_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) bus_n ();

  assign bus_b.iReadRegister  = {ra1, ra0};
  assign bus_b.iWriteRegister = waddr;
  assign bus_b.iWriteData     = wdata;
  assign bus_b.iRegWrite      = we;
  assign bus_b.iWrite32       = w32;
  assign bus_b.iRegDispSelect = disp;
  assign bus_n.iReadRegister  = {ra1, ra0};
  assign bus_n.iWriteRegister = waddr;
  assign bus_n.iWriteData     = wdata;
  assign bus_n.iRegWrite      = we;
  assign bus_n.iWrite32       = w32;
  assign bus_n.iRegDispSelect = disp;

  legv8_regbank_param #(.BYPASS(1)) dut_b (.iCLK(iCLK), .iCLR(clr), .bus(bus_b));
  legv8_regbank_param #(.BYPASS(0)) dut_n (.iCLK(iCLK), .iCLR(clr), .bus(bus_n));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mregs [32];
  bit          mbusy = 1'b0;
  int          mrem  = 0;

  function automatic logic [63:0] mval(input logic [63:0] d, input logic is32);
    return is32 ? {32'h0, d[31:0]} : d;
  endfunction

  function automatic logic [63:0] mread(input logic [4:0] a, input bit byp);
    if (mbusy || a == 5'd31) return 64'h0;
    if (byp && we && !clr && a == waddr && waddr != 5'd31) return mval(wdata, w32);
    return mregs[a];
  endfunction

  task automatic mupdate();
    if (clr) begin
      mbusy = 1'b1;
      mrem  = 32;
    end else if (mbusy) begin
      mrem--;
      if (mrem == 0) begin
        mbusy = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = (i == 28) ? 64'd65400 : 64'd0;
      end
    end else if (we && waddr != 5'd31) begin
      mregs[waddr] = mval(wdata, w32);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_b_rd0"}, bus_b.oReadData[63:0],   mread(ra0, 1'b1));
    chk({tag, "_b_rd1"}, bus_b.oReadData[127:64], mread(ra1, 1'b1));
    chk({tag, "_n_rd0"}, bus_n.oReadData[63:0],   mread(ra0, 1'b0));
    chk({tag, "_n_rd1"}, bus_n.oReadData[127:64], mread(ra1, 1'b0));
    chk({tag, "_disp"},  bus_b.oRegDisp,
        (mbusy || disp == 5'd31) ? 64'h0 : mregs[disp]);
    chk({tag, "_busy"},  {63'h0, bus_b.oBusy}, {63'h0, mbusy});
  endtask

  // Inputs are set just after a negedge; sample mid-cycle, then clock.
  task automatic tick(input bit do_check, input string tag);
    #1;
    if (do_check) check_all(tag);
    @(posedge iCLK);
    mupdate();
    @(negedge iCLK);
  endtask

  // Counts pre-edge samples with busy high after reset release.
  task automatic poll_clear(input string tag, input bit mid_write, output int n);
    n = 0;
    clr = 1'b0;
    while (n < 100) begin
      we    = (mid_write && n == 3);
      waddr = 5'd5;
      wdata = 64'hDEAD_BEEF_0000_0001;
      ra0   = 5'd5;
      ra1   = 5'd28;
      #1;
      if (bus_b.oBusy !== 1'b1) break;
      check_all(tag);
      n++;
      @(posedge iCLK);
      mupdate();
      @(negedge iCLK);
    end
    we = 1'b0;
    @(negedge iCLK);
  endtask

  typedef struct {
    logic        we, w32;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [4:0]  r0, r1, dsel;
    logic [63:0] e0, e1, e0nb, edisp;
  } vec_t;

  vec_t tbl [8];
  int   n;

  initial begin
    tbl[0] = '{1, 0, 5'd7,  64'h1234,                5'd7,  5'd28, 5'd7,
               64'h1234, 64'd65400, 64'h0, 64'h0};
    tbl[1] = '{0, 0, 5'd7,  64'h0,                   5'd7,  5'd31, 5'd7,
               64'h1234, 64'h0, 64'h1234, 64'h1234};
    tbl[2] = '{1, 0, 5'd31, 64'hFFFF,                5'd31, 5'd31, 5'd31,
               64'h0, 64'h0, 64'h0, 64'h0};
    tbl[3] = '{0, 0, 5'd31, 64'h0,                   5'd31, 5'd5,  5'd31,
               64'h0, 64'h0, 64'h0, 64'h0};
    tbl[4] = '{1, 1, 5'd9,  64'hFFFF_FFFF_8000_0001, 5'd9,  5'd7,  5'd9,
               64'h8000_0001, 64'h1234, 64'h0, 64'h0};
    tbl[5] = '{0, 0, 5'd9,  64'h0,                   5'd9,  5'd9,  5'd9,
               64'h8000_0001, 64'h8000_0001, 64'h8000_0001, 64'h8000_0001};
    tbl[6] = '{1, 0, 5'd30, 64'hAAAA_5555_AAAA_5555, 5'd30, 5'd29, 5'd30,
               64'hAAAA_5555_AAAA_5555, 64'h0, 64'h0, 64'h0};
    tbl[7] = '{0, 0, 5'd0,  64'h0,                   5'd28, 5'd30, 5'd28,
               64'd65400, 64'hAAAA_5555_AAAA_5555, 64'd65400, 64'd65400};

    clr = 1'b1; we = 1'b0; w32 = 1'b0; waddr = '0; wdata = '0;
    ra0 = '0; ra1 = '0; disp = '0;

    // Reset for two edges; the second cycle checks reset-state outputs.
    tick(1'b0, "rst0");
    ra0 = 5'd28; ra1 = 5'd3; disp = 5'd28;
    tick(1'b1, "rst1");

    // Initial clear with a write to X5 at clear cycle 3 (must be dropped).
    poll_clear("clr", 1'b1, n);
    chk("busy_len", 64'(n), 64'd32);

    // Post-clear contents via both ports and the display.
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i); disp = 5'(i);
      #1;
      chk("sweep_rd0",  bus_b.oReadData[63:0],   (i == 28) ? 64'd65400 : 64'd0);
      chk("sweep_rd1",  bus_n.oReadData[127:64], (31 - i == 28) ? 64'd65400 : 64'd0);
      chk("sweep_disp", bus_n.oRegDisp,          (i == 28) ? 64'd65400 : 64'd0);
      @(negedge iCLK);
    end

    // Directed vectors: bypass, XZR, W-register writes.
    for (int v = 0; v < 8; v++) begin
      we = tbl[v].we; w32 = tbl[v].w32; waddr = tbl[v].waddr; wdata = tbl[v].wdata;
      ra0 = tbl[v].r0; ra1 = tbl[v].r1; disp = tbl[v].dsel;
      #1;
      chk("tbl_b_rd0", bus_b.oReadData[63:0],   tbl[v].e0);
      chk("tbl_b_rd1", bus_b.oReadData[127:64], tbl[v].e1);
      chk("tbl_n_rd0", bus_n.oReadData[63:0],   tbl[v].e0nb);
      chk("tbl_n_rd1", bus_n.oReadData[127:64], tbl[v].e1);
      chk("tbl_disp",  bus_b.oRegDisp,          tbl[v].edisp);
      @(posedge iCLK);
      mupdate();
      @(negedge iCLK);
    end
    we = 1'b0; w32 = 1'b0;

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      clr   = ($urandom_range(0, 149) == 0);
      we    = $urandom_range(0, 1);
      w32   = ($urandom_range(0, 3) == 0);
      waddr = 5'($urandom_range(0, 31));
      wdata = {$urandom, $urandom};
      ra0   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      ra1   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      disp  = ($urandom_range(0, 1) == 0) ? waddr : 5'($urandom_range(0, 31));
      tick(1'b1, "rnd");
    end
    clr = 1'b0; we = 1'b0;
    for (int c = 0; c < 40 && mbusy; c++) tick(1'b1, "drain");

    // Restart: reset in IDLE together with a write to X3, reset again at
    // clear cycle 10, then a full clear must follow the second release.
    we = 1'b1; w32 = 1'b0; waddr = 5'd3; wdata = 64'd5; ra0 = 5'd3; ra1 = 5'd3;
    tick(1'b1, "pre_x3");
    clr = 1'b1; wdata = 64'd77;
    tick(1'b1, "clr_wr");
    clr = 1'b0; we = 1'b0;
    for (int c = 0; c < 10; c++) tick(1'b1, "part");
    chk("part_busy", {63'h0, bus_b.oBusy}, 64'h1);
    clr = 1'b1;
    tick(1'b1, "restart");
    poll_clear("reclr", 1'b0, n);
    chk("restart_len", 64'(n), 64'd32);
    ra0 = 5'd3; ra1 = 5'd28; disp = 5'd3;
    #1;
    chk("x3_cleared", bus_b.oReadData[63:0], 64'h0);
    chk("x3_disp",    bus_n.oRegDisp,        64'h0);
    chk("sp_reinit",  bus_n.oReadData[127:64], 64'd65400);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
